// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types, constants and cycle decode for mem_bus_responder
package mem_bus_pkg;

    localparam int         HALF_SEL_BIT = 6;
    localparam logic [3:0] HALT_NIBBLE  = 4'b0000;

    typedef enum logic [1:0] {
        READ,
        WADDR,
        COMMIT,
        HALT
    } bus_cycle_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_COMMIT,
        HALTED
    } resp_state_e;

    function automatic bus_cycle_e decode_cycle(input logic read_write, input logic write_commit);
        case ({read_write, write_commit})
            2'b10:   return READ;
            2'b00:   return WADDR;
            2'b01:   return COMMIT;
            default: return HALT;
        endcase
    endfunction

endpackage

// File: rtl/mem_array_1r1w.sv
// rtl/mem_array_1r1w.sv - word array with registered read port and half-word write enables
module mem_array_1r1w #(
    parameter int              ADDR_W   = 10,
    parameter int              WORD_W   = 12,
    parameter logic [WORD_W-1:0] RD_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [1:0]        wr_be
);

    localparam int HALF = WORD_W / 2;

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we && wr_be[0]) begin
            mem[wr_addr][HALF-1:0] <= wr_data[HALF-1:0];
        end
        if (we && wr_be[1]) begin
            mem[wr_addr][WORD_W-1:HALF] <= wr_data[WORD_W-1:HALF];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= RD_RESET;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - CPU memory bus responder; MEM_BUS_RESP_STATS_EN adds rd/wr counters
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W       = 10,
    parameter int                WORD_W       = 12,
    parameter logic [WORD_W-1:0] RESET_RESULT = 12'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_data,
    input  logic              read_write,
    input  logic              write_commit,
    output logic [WORD_W-1:0] mem_result,
    output logic              halted,
    output logic              proto_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    output logic              prog_ready
`ifdef MEM_BUS_RESP_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int HALF = WORD_W / 2;

    resp_state_e       state;
    logic [ADDR_W-1:0] wr_addr;
    bus_cycle_e        cyc;
    logic              rd_en;
    logic              commit_we;
    logic              host_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_wr_addr;
    logic [WORD_W-1:0] arr_wr_data;
    logic [1:0]        arr_wr_be;

    always_comb begin
        cyc        = decode_cycle(read_write, write_commit);
        rd_en      = (state != HALTED) && (cyc == READ);
        commit_we  = (state == WAIT_COMMIT) && (cyc == COMMIT);
        prog_ready = ((state == IDLE) || (state == HALTED)) && (cyc != COMMIT);
        host_we    = prog_we && prog_ready;
    end

    // The commit payload is replicated into both halves; the byte-enable picks the target half.
    always_comb begin
        arr_we      = commit_we || host_we;
        arr_wr_addr = prog_addr;
        arr_wr_data = prog_data;
        arr_wr_be   = 2'b11;
        if (commit_we) begin
            arr_wr_addr = wr_addr;
            arr_wr_data = {2{addr_data[HALF-1:0]}};
            arr_wr_be   = addr_data[HALF_SEL_BIT] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            halted    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (cyc)
                        WADDR: begin
                            wr_addr <= addr_data;
                            state   <= WAIT_COMMIT;
                        end
                        COMMIT: proto_err <= 1'b1;
                        HALT: begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                WAIT_COMMIT: begin
                    case (cyc)
                        COMMIT: state <= IDLE;
                        // The CPU may repeat the address phase while stalled; the latest address wins.
                        WADDR: wr_addr <= addr_data;
                        READ: begin
                            proto_err <= 1'b1;
                            state     <= IDLE;
                        end
                        default: begin
                            proto_err <= 1'b1;
                            state     <= HALTED;
                            halted    <= 1'b1;
                        end
                    endcase
                end
                HALTED: ;
                default: state <= IDLE;
            endcase
        end
    end

    mem_array_1r1w #(
        .ADDR_W   (ADDR_W),
        .WORD_W   (WORD_W),
        .RD_RESET (RESET_RESULT)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (addr_data),
        .rd_data (mem_result),
        .we      (arr_we),
        .wr_addr (arr_wr_addr),
        .wr_data (arr_wr_data),
        .wr_be   (arr_wr_be)
    );

`ifdef MEM_BUS_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_en && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (commit_we && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - table-driven scoreboard bench for mem_bus_responder
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr_data;
    logic        read_write;
    logic        write_commit;
    logic [11:0] mem_result;
    logic        halted;
    logic        proto_err;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [11:0] prog_data;
    logic        prog_ready;
`ifdef MEM_BUS_RESP_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    always #5 clk = ~clk;

    mem_bus_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_data    (addr_data),
        .read_write   (read_write),
        .write_commit (write_commit),
        .mem_result   (mem_result),
        .halted       (halted),
        .proto_err    (proto_err),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_ready   (prog_ready)
`ifdef MEM_BUS_RESP_STATS_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    typedef struct {
        bit          rst;
        bit          rw;
        bit          wc;
        logic [9:0]  addr;
        bit          pwe;
        logic [9:0]  paddr;
        logic [11:0] pdata;
        bit          chk;
        logic [11:0] res;
        bit          halt;
        bit          err;
        bit          rdy;
    } vec_t;

    typedef struct {
        int          row;
        bit          chk;
        logic [11:0] res;
        bit          halt;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int row, input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, got, want);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit rw, input bit wc, input logic [9:0] addr,
                                input bit pwe, input logic [9:0] paddr, input logic [11:0] pdata,
                                input bit chk, input logic [11:0] res, input bit halt, input bit err,
                                input bit rdy);
        vec_t v;
        v.rst = rst; v.rw = rw; v.wc = wc; v.addr = addr;
        v.pwe = pwe; v.paddr = paddr; v.pdata = pdata;
        v.chk = chk; v.res = res; v.halt = halt; v.err = err; v.rdy = rdy;
        return v;
    endfunction

    task automatic drive(input bit rw, input bit wc, input logic [9:0] addr,
                         input bit pwe, input logic [9:0] paddr, input logic [11:0] pdata);
        read_write   = rw;
        write_commit = wc;
        addr_data    = addr;
        prog_we      = pwe;
        prog_addr    = paddr;
        prog_data    = pdata;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // Preload (bus reads addr 0 as filler)
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h000,12'h111, 0,12'h000,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h005,12'hABC, 1,12'h111,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h020,12'h000, 1,12'h111,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h030,12'h333, 1,12'h111,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h031,12'h31A, 1,12'h111,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h040,12'h5C3, 1,12'h111,0,0,1));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h051,12'h051, 1,12'h111,0,0,1));
        // Read latency and two-phase store
        vecs.push_back(mk(0,1,0,10'h005, 0,10'h000,12'h000, 1,12'hABC,0,0,1));
        vecs.push_back(mk(0,0,0,10'h020, 0,10'h000,12'h000, 1,12'hABC,0,0,1));
        vecs.push_back(mk(0,0,1,10'h06A, 0,10'h000,12'h000, 1,12'hABC,0,0,0));
        vecs.push_back(mk(0,1,0,10'h020, 0,10'h000,12'h000, 1,12'hA80,0,0,1));
        // Repeated address phase: latest wins, lower-half commit
        vecs.push_back(mk(0,0,0,10'h020, 0,10'h000,12'h000, 1,12'hA80,0,0,1));
        vecs.push_back(mk(0,0,0,10'h040, 0,10'h000,12'h000, 1,12'hA80,0,0,0));
        vecs.push_back(mk(0,0,1,10'h015, 0,10'h000,12'h000, 1,12'hA80,0,0,0));
        vecs.push_back(mk(0,1,0,10'h020, 0,10'h000,12'h000, 1,12'hA80,0,0,1));
        vecs.push_back(mk(0,1,0,10'h040, 0,10'h000,12'h000, 1,12'h5D5,0,0,1));
        // Commit in IDLE: error, no write
        vecs.push_back(mk(0,0,1,10'h07F, 0,10'h000,12'h000, 1,12'h5D5,0,1,0));
        vecs.push_back(mk(0,1,0,10'h040, 0,10'h000,12'h000, 1,12'h5D5,0,1,1));
        // Abandoned store
        vecs.push_back(mk(1,1,0,10'h005, 0,10'h000,12'h000, 1,12'hABC,0,0,1));
        vecs.push_back(mk(0,0,0,10'h030, 0,10'h000,12'h000, 1,12'hABC,0,0,1));
        vecs.push_back(mk(0,1,0,10'h031, 0,10'h000,12'h000, 1,12'h31A,0,1,0));
        vecs.push_back(mk(0,1,0,10'h030, 0,10'h000,12'h000, 1,12'h333,0,1,1));
        // Halt: bus ignored, host port live
        vecs.push_back(mk(0,1,1,10'h000, 0,10'h000,12'h000, 1,12'h333,1,1,1));
        vecs.push_back(mk(0,1,0,10'h005, 0,10'h000,12'h000, 1,12'h333,1,1,1));
        vecs.push_back(mk(0,0,0,10'h000, 0,10'h000,12'h000, 1,12'h333,1,1,1));
        vecs.push_back(mk(0,0,1,10'h07F, 1,10'h051,12'h777, 1,12'h333,1,1,0));
        vecs.push_back(mk(0,1,0,10'h000, 1,10'h050,12'h777, 1,12'h333,1,1,1));
        vecs.push_back(mk(1,1,0,10'h050, 0,10'h000,12'h000, 1,12'h777,0,0,1));
        // Host write collides with commit: dropped, retry accepted
        vecs.push_back(mk(0,0,0,10'h020, 0,10'h000,12'h000, 1,12'h777,0,0,1));
        vecs.push_back(mk(0,0,1,10'h015, 1,10'h051,12'h777, 1,12'h777,0,0,0));
        vecs.push_back(mk(0,1,0,10'h051, 0,10'h000,12'h000, 1,12'h051,0,0,1));
        vecs.push_back(mk(0,1,0,10'h020, 1,10'h051,12'h777, 1,12'hA95,0,0,1));
        vecs.push_back(mk(0,1,0,10'h051, 0,10'h000,12'h000, 1,12'h777,0,0,1));
        // Reset mid-store loses the pending store
        vecs.push_back(mk(0,0,0,10'h031, 0,10'h000,12'h000, 1,12'h777,0,0,1));
        vecs.push_back(mk(1,0,1,10'h07F, 0,10'h000,12'h000, 1,12'h000,0,1,0));
        vecs.push_back(mk(0,1,0,10'h031, 0,10'h000,12'h000, 1,12'h31A,0,1,1));

        rst_n = 1'b0;
        drive(1, 0, 10'h000, 0, 10'h000, 12'h000);
        #2;
        check("reset_mem_result", -1, mem_result, 12'h000);
        check("reset_halted", -1, {11'd0, halted}, 12'd0);
        check("reset_proto_err", -1, {11'd0, proto_err}, 12'd0);
        check("reset_prog_ready", -1, {11'd0, prog_ready}, 12'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) pulse_reset();
            drive(vecs[i].rw, vecs[i].wc, vecs[i].addr, vecs[i].pwe, vecs[i].paddr, vecs[i].pdata);
            #1;
            check("prog_ready", i, {11'd0, prog_ready}, {11'd0, vecs[i].rdy});
            e.row = i; e.chk = vecs[i].chk; e.res = vecs[i].res;
            e.halt = vecs[i].halt; e.err = vecs[i].err;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (e.chk) check("mem_result", e.row, mem_result, e.res);
            check("halted", e.row, {11'd0, halted}, {11'd0, e.halt});
            check("proto_err", e.row, {11'd0, proto_err}, {11'd0, e.err});
        end

        // HALT while a store is pending
        pulse_reset();
        drive(0, 0, 10'h020, 0, 10'h000, 12'h000);
        @(posedge clk);
        #1;
        drive(1, 1, 10'h000, 0, 10'h000, 12'h000);
        @(posedge clk);
        #1;
        check("halt_in_wait_err", 100, {11'd0, proto_err}, 12'd1);
        check("halt_in_wait_halted", 100, {11'd0, halted}, 12'd1);

        // Asynchronous reset takes effect without a clock edge
        drive(1, 0, 10'h005, 0, 10'h000, 12'h000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_halted", 101, {11'd0, halted}, 12'd0);
        check("async_proto_err", 101, {11'd0, proto_err}, 12'd0);
        check("async_mem_result", 101, mem_result, 12'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_read", 102, mem_result, 12'hABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
